// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM states, SRAM geometry and
// the default byte address of SRAM word 0.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;
    localparam int unsigned SRAM_ADDR_W      = 18;
    localparam int unsigned SRAM_DATA_W      = 16;
    localparam int unsigned WORD_IDX_W       = SRAM_ADDR_W - 1;

    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/sram_mem_stage_if.sv
// Pipeline request/response and SRAM pin bundle of the memory stage.
// The slave modport is the stage itself; master is its environment.
interface sram_mem_stage_if;
    import mem_pkg::*;

    logic                   mem_read_in;
    logic                   mem_write_in;
    logic [31:0]            alu_res_in;
    logic [31:0]            val_rm_in;
    logic                   ready;
    logic [31:0]            mem_data_out;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_wdata;
    logic                   sram_dq_oe;
    logic [SRAM_DATA_W-1:0] sram_rdata;
    logic                   sram_ce_n;
    logic                   sram_oe_n;
    logic                   sram_we_n;
    logic                   sram_ub_n;
    logic                   sram_lb_n;

    modport slave (
        input  mem_read_in, mem_write_in, alu_res_in, val_rm_in, sram_rdata,
        output ready, mem_data_out, sram_addr, sram_wdata, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output mem_read_in, mem_write_in, alu_res_in, val_rm_in, sram_rdata,
        input  ready, mem_data_out, sram_addr, sram_wdata, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

endinterface

// File: rtl/sram_mem_stage_wait_counter.sv
// Per-phase wait counter: counts 1..SRAM_WAIT inside a half-word phase and
// flags the final count.
module sram_wait_counter
    import mem_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = 5,
    parameter int unsigned CNT_W     = cnt_width(SRAM_WAIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] base_s;
    logic [CNT_W-1:0] next_s;

    // Next count; clear together with enable restarts at 1 for the phase being entered.
    always_comb begin
        base_s = count_r;
        next_s = count_r;
        if (clr) begin
            base_s = {CNT_W{1'b0}};
        end else begin
            base_s = count_r;
        end
        if (en) begin
            next_s = base_s + CNT_W'(1);
        end else begin
            next_s = base_s;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= next_s;
        end
    end

    assign count = count_r;
    assign last  = (count_r == CNT_W'(SRAM_WAIT));

endmodule

// File: rtl/sram_mem_stage.sv
// Memory stage: one 32-bit load/store as two timed half-word accesses on a
// 16-bit asynchronous SRAM, freezing the pipeline while the access runs.
module sram_mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = 5,
    parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    sram_mem_stage_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(SRAM_WAIT);

    state_e                 state_r;
    state_e                 next_state_s;
    logic                   req_s;
    logic                   accept_s;
    logic                   phase_s;
    logic                   clr_s;
    logic                   en_s;
    logic [CNT_W-1:0]       cnt_s;
    logic                   last_s;
    logic [WORD_IDX_W-1:0]  word_idx_s;
    logic                   is_write_r;
    logic [SRAM_ADDR_W-1:0] addr_r;
    logic [SRAM_DATA_W-1:0] wdata_r;
    logic [SRAM_DATA_W-1:0] wdata_hi_r;
    logic [SRAM_DATA_W-1:0] load_lo_r;
    logic [31:0]            data_r;

    assign req_s      = bus.mem_read_in | bus.mem_write_in;
    assign accept_s   = (state_r == ST_IDLE) & req_s;
    assign phase_s    = (state_r == ST_LO) | (state_r == ST_HI);
    // No range check: out-of-window addresses simply wrap in the 17-bit word index.
    assign word_idx_s = WORD_IDX_W'((bus.alu_res_in - MEM_BASE) >> 2);

    // Phase sequencing.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) next_state_s = ST_LO;
                else       next_state_s = ST_IDLE;
            end
            ST_LO: begin
                if (last_s) next_state_s = ST_HI;
                else        next_state_s = ST_LO;
            end
            ST_HI: begin
                if (last_s) next_state_s = ST_DONE;
                else        next_state_s = ST_HI;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    assign clr_s = (next_state_s != state_r);
    assign en_s  = (next_state_s == ST_LO) | (next_state_s == ST_HI);

    sram_wait_counter #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .en    (en_s),
        .count (cnt_s),
        .last  (last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch, half-word switch-over and load data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_write_r <= 1'b0;
            addr_r     <= {SRAM_ADDR_W{1'b0}};
            wdata_r    <= {SRAM_DATA_W{1'b0}};
            wdata_hi_r <= {SRAM_DATA_W{1'b0}};
            load_lo_r  <= {SRAM_DATA_W{1'b0}};
            data_r     <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                is_write_r <= bus.mem_write_in;
                addr_r     <= {word_idx_s, 1'b0};
                wdata_r    <= bus.val_rm_in[15:0];
                wdata_hi_r <= bus.val_rm_in[31:16];
            end else if ((state_r == ST_LO) && last_s) begin
                addr_r[0] <= 1'b1;
                wdata_r   <= wdata_hi_r;
                if (!is_write_r) begin
                    load_lo_r <= bus.sram_rdata;
                end
            end else if ((state_r == ST_HI) && last_s && !is_write_r) begin
                data_r <= {bus.sram_rdata, load_lo_r};
            end
        end
    end

    // WE rises on the final count so write data stays driven past the WE edge.
    assign bus.sram_ce_n    = ~phase_s;
    assign bus.sram_ub_n    = ~phase_s;
    assign bus.sram_lb_n    = ~phase_s;
    assign bus.sram_oe_n    = ~(phase_s & ~is_write_r);
    assign bus.sram_we_n    = ~(phase_s & is_write_r & (cnt_s < CNT_W'(SRAM_WAIT)));
    assign bus.sram_dq_oe   = phase_s & is_write_r;
    assign bus.sram_addr    = addr_r;
    assign bus.sram_wdata   = wdata_r;
    assign bus.mem_data_out = data_r;
    assign bus.ready        = ~rst | (state_r == ST_DONE) | ((state_r == ST_IDLE) & ~req_s);

endmodule

// File: tb/tb_sram_mem_stage.sv
// Directed bench for sram_mem_stage: a behavioural SRAM on the pins plus a
// per-cycle model of the expected strobes, address, data and ready.
module tb_sram_mem_stage;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sram_mem_stage_if bus ();

    sram_mem_stage #(
        .SRAM_WAIT (W),
        .MEM_BASE  (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM, addressed by half-word.
    logic [15:0] sram [logic [17:0]];
    logic        we_seen = 1'b0;

    always @(negedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_oe_n && sram.exists(bus.sram_addr))
            bus.sram_rdata = sram[bus.sram_addr];
        else
            bus.sram_rdata = 16'hA5A5;
    end

    // A write lands when WE has been low and then a held-data cycle follows with CE still low.
    always @(posedge clk) begin
        if (bus.sram_ce_n) begin
            we_seen = 1'b0;
        end else if (!bus.sram_we_n) begin
            we_seen = 1'b1;
        end else if (we_seen && bus.sram_dq_oe) begin
            sram[bus.sram_addr] = bus.sram_wdata;
            we_seen = 1'b0;
        end
    end

    // Reference memory contents as implied by completed (or partially completed) stores.
    logic [15:0] model_half [logic [17:0]];

    logic        e_ready, e_strb_n, e_oe_n, e_we_n, e_dq_oe, e_addr_vld, e_wdata_vld;
    logic [17:0] e_addr;
    logic [15:0] e_wdata;
    logic [31:0] e_data;

    function automatic logic [15:0] model_rd(input logic [17:0] a);
        if (model_half.exists(a)) return model_half[a];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] sram_rd(input logic [17:0] a);
        if (sram.exists(a)) return sram[a];
        return 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the current expectations, then move to the next cycle.
    task automatic step();
        @(negedge clk);
        chk("ready",    32'(bus.ready),        32'(e_ready));
        chk("ce_n",     32'(bus.sram_ce_n),    32'(e_strb_n));
        chk("ub_n",     32'(bus.sram_ub_n),    32'(e_strb_n));
        chk("lb_n",     32'(bus.sram_lb_n),    32'(e_strb_n));
        chk("oe_n",     32'(bus.sram_oe_n),    32'(e_oe_n));
        chk("we_n",     32'(bus.sram_we_n),    32'(e_we_n));
        chk("dq_oe",    32'(bus.sram_dq_oe),   32'(e_dq_oe));
        chk("mem_data", bus.mem_data_out,      e_data);
        if (e_addr_vld)  chk("sram_addr",  32'(bus.sram_addr),  32'(e_addr));
        if (e_wdata_vld) chk("sram_wdata", 32'(bus.sram_wdata), 32'(e_wdata));
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        e_ready     = 1'b1;
        e_strb_n    = 1'b1;
        e_oe_n      = 1'b1;
        e_we_n      = 1'b1;
        e_dq_oe     = 1'b0;
        e_addr_vld  = 1'b0;
        e_wdata_vld = 1'b0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.mem_read_in  = 1'b0;
            bus.mem_write_in = 1'b0;
            bus.alu_res_in   = $urandom();
            bus.val_rm_in    = $urandom();
            set_idle_exp();
            step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready),      32'd1);
        chk({tag, "_ce_n"},  32'(bus.sram_ce_n),  32'd1);
        chk({tag, "_we_n"},  32'(bus.sram_we_n),  32'd1);
        chk({tag, "_oe_n"},  32'(bus.sram_oe_n),  32'd1);
        chk({tag, "_ub_n"},  32'(bus.sram_ub_n),  32'd1);
        chk({tag, "_lb_n"},  32'(bus.sram_lb_n),  32'd1);
        chk({tag, "_dq_oe"}, 32'(bus.sram_dq_oe), 32'd0);
        chk({tag, "_addr"},  32'(bus.sram_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(bus.sram_wdata), 32'd0);
        chk({tag, "_data"},  bus.mem_data_out,    32'd0);
    endtask

    // One access; cycle k counts from the IDLE request cycle. abort_k >= 0 pulses reset in that cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input int abort_k);
        logic        store;
        logic [16:0] idx;
        logic [17:0] a_lo, a_hi;
        logic        hi, act;
        int          c;
        store = wr;
        idx   = 17'((addr - BASE) >> 2);
        a_lo  = {idx, 1'b0};
        a_hi  = {idx, 1'b1};
        for (int k = 0; k <= 2 * W + 1; k++) begin
            if (k == 0) begin
                bus.mem_read_in  = rd;
                bus.mem_write_in = wr;
                bus.alu_res_in   = addr;
                bus.val_rm_in    = data;
            end else begin
                bus.mem_read_in  = wr;
                bus.mem_write_in = rd;
                bus.alu_res_in   = addr ^ 32'h0000_0F0C;
                bus.val_rm_in    = ~data;
            end
            if (k == abort_k) begin
                bus.mem_read_in  = 1'b0;
                bus.mem_write_in = 1'b0;
                #1 rst = 1'b0;
                #1 check_reset_outputs("abort");
                #1 rst = 1'b1;
                if (store && k > W) model_half[a_lo] = data[15:0];
                e_data = 32'h0000_0000;
                set_idle_exp();
                step();
                return;
            end
            hi          = (k > W);
            c           = hi ? k - W : k;
            act         = (k >= 1) && (k <= 2 * W);
            e_ready     = (k == 2 * W + 1);
            e_strb_n    = !act;
            e_oe_n      = !(act && !store);
            e_we_n      = !(act && store && (c < W));
            e_dq_oe     = act && store;
            e_addr_vld  = act;
            e_addr      = hi ? a_hi : a_lo;
            e_wdata_vld = act && store;
            e_wdata     = hi ? data[31:16] : data[15:0];
            if (k == 2 * W + 1) begin
                if (store) begin
                    model_half[a_lo] = data[15:0];
                    model_half[a_hi] = data[31:16];
                end else begin
                    e_data = {model_rd(a_hi), model_rd(a_lo)};
                end
            end
            step();
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        e_data           = 32'h0000_0000;
        rst              = 1'b0;
        bus.mem_read_in  = 1'b1;
        bus.mem_write_in = 1'b0;
        bus.alu_res_in   = 32'd1032;
        bus.val_rm_in    = 32'h0000_0000;
        bus.sram_rdata   = 16'h0000;
        #3 check_reset_outputs("reset");
        @(posedge clk);
        #1 bus.mem_read_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        run_idle(2);

        // Store, then load back the same word.
        run_access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, -1);
        chk("lit_sram4", 32'(sram_rd(18'd4)), 32'h0000_BEEF);
        chk("lit_sram5", 32'(sram_rd(18'd5)), 32'h0000_DEAD);
        run_access(1'b1, 1'b0, 32'd1032, 32'h0000_0000, -1);
        chk("lit_load1", bus.mem_data_out, 32'hDEAD_BEEF);

        // Load immediately followed by a store to the next word.
        run_access(1'b1, 1'b0, 32'd1032, 32'h0000_0000, -1);
        run_access(1'b0, 1'b1, 32'd1036, 32'h0BAD_F00D, -1);
        chk("lit_sram6", 32'(sram_rd(18'd6)), 32'h0000_F00D);
        chk("lit_sram7", 32'(sram_rd(18'd7)), 32'h0000_0BAD);

        // Non-memory cycles leave the loaded word alone.
        run_access(1'b0, 1'b1, 32'd1040, 32'h1234_5678, -1);
        run_access(1'b1, 1'b0, 32'd1040, 32'h0000_0000, -1);
        run_idle(3);
        chk("lit_load2", bus.mem_data_out, 32'h1234_5678);

        // Read and write together behave as a store.
        run_access(1'b1, 1'b1, 32'd1044, 32'h55AA_33CC, -1);
        chk("lit_sram10", 32'(sram_rd(18'd10)), 32'h0000_33CC);
        chk("lit_sram11", 32'(sram_rd(18'd11)), 32'h0000_55AA);
        chk("lit_both_data", bus.mem_data_out, 32'h1234_5678);

        // Reset in cycle 7 of a store: only the low half reaches the SRAM.
        run_access(1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, 7);
        run_idle(1);
        chk("lit_abort_sram4", 32'(sram_rd(18'd4)), 32'h0000_F00D);
        chk("lit_abort_sram5", 32'(sram_rd(18'd5)), 32'h0000_DEAD);
        run_access(1'b1, 1'b0, 32'd1032, 32'h0000_0000, -1);
        chk("lit_load3", bus.mem_data_out, 32'hDEAD_F00D);

        // Address below the base wraps to the top of the word space.
        run_access(1'b0, 1'b1, 32'd1020, 32'h1357_9BDF, -1);
        chk("lit_wrap_lo", 32'(sram_rd(18'h3FFFE)), 32'h0000_9BDF);
        run_access(1'b1, 1'b0, 32'd1020, 32'h0000_0000, -1);
        chk("lit_wrap_load", bus.mem_data_out, 32'h1357_9BDF);
        run_idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
